// File: rtl/cache_mem_responder.sv
// cache_mem_responder: arbitrates per-CPU dcache/icache requests onto one single-port RAM
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   dREN/dWEN/daddr/dstore  per-CPU dcache requests (32-bit slices packed by CPU)
//   iREN/iaddr           per-CPU icache read requests
//   dwait/iwait          per-CPU stalls, low only in the completing cycle
//   dload/iload          read data, every slice carries ramload
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate  RAM side
//   gnt_valid/gnt_cpu/gnt_type  current grant (type 0 dread, 1 dwrite, 2 iread)
module cache_mem_responder #(
    parameter int CPUS = 2,
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   dload,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS*32-1:0]   iload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate,
    output logic                 gnt_valid,
    output logic [CW-1:0]        gnt_cpu,
    output logic [1:0]           gnt_type
);
    typedef enum logic {ARB, SERVE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] rr_q, rr_d, gnt_cpu_q, gnt_cpu_d;
    logic [1:0] gnt_type_q, gnt_type_d;
    logic serve, live, done;
    logic [31:0] da [CPUS];
    logic [31:0] ds [CPUS];
    logic [31:0] ia [CPUS];
    for (genvar g = 0; g < CPUS; g++) begin : g_unpack
        assign da[g] = daddr[g*32 +: 32];
        assign ds[g] = dstore[g*32 +: 32];
        assign ia[g] = iaddr[g*32 +: 32];
    end
    // First set bit searching upward from start, wrapping: rotate so start sits at bit 0,
    // take the lowest set bit, then add start back modulo CPUS.
    function automatic logic [CW-1:0] rr_pick(input logic [CPUS-1:0] v, input logic [CW-1:0] start);
        logic [2*CPUS-1:0] dbl;
        logic [CW:0] sum;
        rr_pick = '0;
        sum = '0;
        dbl = {v, v} >> start;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                sum = {1'b0, start} + (CW+1)'(j);
                rr_pick = (sum >= (CW+1)'(CPUS)) ? CW'(sum - (CW+1)'(CPUS)) : sum[CW-1:0];
            end
        end
    endfunction
    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        gnt_cpu_d = gnt_cpu_q;
        gnt_type_d = gnt_type_q;
        // Outputs look like ARB whenever reset is asserted, even if state_q is still SERVE.
        serve = nRST && (state_q == SERVE);
        live = (gnt_type_q == 2'd1) ? dWEN[gnt_cpu_q] :
               (gnt_type_q == 2'd0) ? dREN[gnt_cpu_q] : iREN[gnt_cpu_q];
        done = serve && live && (ramstate == 2'd2);
        if (state_q == ARB) begin
            if (|dWEN) begin
                gnt_type_d = 2'd1;
                gnt_cpu_d = rr_pick(dWEN, rr_q);
                state_d = SERVE;
            end else if (|dREN) begin
                gnt_type_d = 2'd0;
                gnt_cpu_d = rr_pick(dREN, rr_q);
                state_d = SERVE;
            end else if (|iREN) begin
                gnt_type_d = 2'd2;
                gnt_cpu_d = rr_pick(iREN, rr_q);
                state_d = SERVE;
            end
        end else if (!live) begin
            state_d = ARB;
        end else if (ramstate == 2'd2) begin
            state_d = ARB;
            rr_d = (gnt_cpu_q == CW'(CPUS - 1)) ? '0 : gnt_cpu_q + 1'b1;
        end
        ramREN = serve && live && (gnt_type_q != 2'd1);
        ramWEN = serve && live && (gnt_type_q == 2'd1);
        ramaddr = !serve ? '0 : (gnt_type_q == 2'd2) ? ia[gnt_cpu_q] : da[gnt_cpu_q];
        ramstore = (serve && gnt_type_q == 2'd1) ? ds[gnt_cpu_q] : '0;
        dwait = ~(CPUS'(done && gnt_type_q != 2'd2) << gnt_cpu_q);
        iwait = ~(CPUS'(done && gnt_type_q == 2'd2) << gnt_cpu_q);
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ARB;
            rr_q <= '0;
            gnt_cpu_q <= '0;
            gnt_type_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            gnt_cpu_q <= gnt_cpu_d;
            gnt_type_q <= gnt_type_d;
        end
    end
    assign dload = {CPUS{ramload}};
    assign iload = {CPUS{ramload}};
    assign gnt_valid = serve;
    assign gnt_cpu = gnt_cpu_q;
    assign gnt_type = gnt_type_q;
endmodule
